zrle_blk_ctrl: RTL and testbench

- Block-level sequencer for the ZRLE compressor path (encoder, then ZRL code buffer).
- Accepts one 512-bit raw block and feeds it to the encoder as 8 x 64-bit beats with sop/eop.
- Collects the packed code-buffer beats and the block size, then decides compressed vs raw.
- Emits the chosen beat stream downstream with a size/compressed-flag sideband.

---
 rtl/zrle_pkg.sv | 19 +
 rtl/zrle_beat_buf.sv | 40 ++++
 rtl/zrle_blk_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_zrle_blk_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zrle_pkg.sv
// ZRLE compressor path shared types and constants.
// Block sequencer states and block geometry.
package zrle_pkg;

  localparam int BLK_BEATS   = 8;
  localparam int BEAT_W      = 64;
  localparam int RAW_LIMIT   = 512;
  localparam int INCOMP_SIZE = 513;
  localparam int SIZE_W      = 11;
  localparam int TIMEOUT     = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT
  } state_t;

endpackage

// File: rtl/zrle_beat_buf.sv
// Small beat register file: parallel load, indexed write,
// indexed read and synchronous clear.
module zrle_beat_buf
  import zrle_pkg::*;
#(
  parameter int DW = BEAT_W,
  parameter int N  = BLK_BEATS,
  localparam int AW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              ld,
  input  logic [DW*N-1:0]   ld_data,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [N];

  // Storage: clear wins over block load, load wins over beat write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (ld) begin
      for (int i = 0; i < N; i++)
        mem[i] <= ld_data[i*DW +: DW];
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/zrle_blk_ctrl.sv
// ZRLE block sequencer: feeds a raw block to the encoder,
// collects the code buffer, then emits compressed or raw.
module zrle_blk_ctrl #(
  parameter int DW        = zrle_pkg::BEAT_W,
  parameter int BEATS     = zrle_pkg::BLK_BEATS,
  parameter int SIZE_W    = zrle_pkg::SIZE_W,
  parameter int RAW_LIMIT = zrle_pkg::RAW_LIMIT,
  parameter int TIMEOUT   = zrle_pkg::TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [DW*BEATS-1:0]  blk_data,
  output logic                 enc_valid,
  input  logic                 enc_ready,
  output logic [DW-1:0]        enc_data,
  output logic                 enc_sop,
  output logic                 enc_eop,
  input  logic                 cb_d_valid,
  input  logic [DW-1:0]        cb_data,
  input  logic                 cb_s_valid,
  input  logic [SIZE_W-1:0]    cb_size,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic                 out_last,
  output logic [SIZE_W-1:0]    hdr_size,
  output logic                 hdr_comp,
  output logic                 busy,
  output logic                 err_timeout
);

  import zrle_pkg::*;

  localparam int AW = $clog2(BEATS);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SH = $clog2(DW);

  state_t state, state_nx;

  logic [AW-1:0]     icnt;
  logic [AW-1:0]     ocnt;
  logic [AW-1:0]     olast;
  logic [CW-1:0]     ccnt;
  logic [TW-1:0]     wcnt;
  logic [SIZE_W-1:0] sz;
  logic              szv;
  logic              ovf;
  logic              perr;
  logic              comp_q;
  logic              zero_q;

  logic [SIZE_W:0]   need;
  logic              accept;
  logic              enc_hs;
  logic              out_hs;
  logic              capture;
  logic              cap_wr;
  logic              go_emit;
  logic              to_hit;
  logic              comp_nx;
  logic [AW-1:0]     raw_ra;
  logic [DW-1:0]     raw_rd;
  logic [DW-1:0]     stg_rd;

  assign accept  = blk_valid && blk_ready;
  assign enc_hs  = enc_valid && enc_ready;
  assign out_hs  = out_valid && out_ready;
  assign capture = (state == ISSUE) || (state == WAIT);
  assign cap_wr  = capture && cb_d_valid
                && (ccnt != CW'(BEATS));
  assign raw_ra  = (state == EMIT) ? ocnt : icnt;

  zrle_beat_buf #(
    .DW (DW),
    .N  (BEATS)
  ) u_raw (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (1'b0),
    .ld      (accept),
    .ld_data (blk_data),
    .we      (1'b0),
    .waddr   ('0),
    .wdata   ('0),
    .raddr   (raw_ra),
    .rdata   (raw_rd)
  );

  zrle_beat_buf #(
    .DW (DW),
    .N  (BEATS)
  ) u_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .ld      (1'b0),
    .ld_data ('0),
    .we      (cap_wr),
    .waddr   (ccnt[AW-1:0]),
    .wdata   (cb_data),
    .raddr   (ocnt),
    .rdata   (stg_rd)
  );

  // Beats needed to carry sz bits; an empty block still sends one beat.
  always_comb begin
    need = ({1'b0, sz} + (SIZE_W+1)'(DW-1)) >> SH;
    if (sz == '0) need = (SIZE_W+1)'(1);
  end

  // Next state, WAIT exit conditions and the compress decision.
  always_comb begin
    state_nx = state;
    go_emit  = 1'b0;
    to_hit   = 1'b0;
    comp_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = ISSUE;
      end
      ISSUE: begin
        if (enc_hs && icnt == AW'(BEATS-1))
          state_nx = WAIT;
      end
      WAIT: begin
        go_emit = (szv && ((SIZE_W+1)'(ccnt) >= need))
               || (sz > SIZE_W'(RAW_LIMIT))
               || ovf || perr;
        to_hit  = !go_emit
               && (wcnt == TW'(TIMEOUT-1));
        comp_nx = szv && !to_hit
               && (sz <= SIZE_W'(RAW_LIMIT))
               && !ovf && !perr;
        if (go_emit || to_hit) state_nx = EMIT;
      end
      EMIT: begin
        if (out_hs && ocnt == olast)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Counters, capture flags, emit decision and header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt        <= '0;
      ocnt        <= '0;
      olast       <= '0;
      ccnt        <= '0;
      wcnt        <= '0;
      sz          <= '0;
      szv         <= 1'b0;
      ovf         <= 1'b0;
      perr        <= 1'b0;
      comp_q      <= 1'b0;
      zero_q      <= 1'b0;
      hdr_size    <= '0;
      hdr_comp    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= to_hit;
      if (accept) begin
        icnt <= '0;
        ocnt <= '0;
        ccnt <= '0;
        wcnt <= '0;
        sz   <= '0;
        szv  <= 1'b0;
        ovf  <= 1'b0;
        perr <= 1'b0;
      end
      if (enc_hs) icnt <= icnt + AW'(1);
      if (capture && cb_d_valid) begin
        if (ccnt == CW'(BEATS)) ovf  <= 1'b1;
        else                    ccnt <= ccnt + CW'(1);
      end
      if (capture && cb_s_valid && !szv) begin
        sz  <= cb_size;
        szv <= 1'b1;
      end
      if (cb_s_valid && state == ISSUE) perr <= 1'b1;
      if (state == WAIT) wcnt <= wcnt + TW'(1);
      if (state == WAIT && state_nx == EMIT) begin
        comp_q   <= comp_nx;
        zero_q   <= comp_nx && (sz == '0);
        ocnt     <= '0;
        olast    <= comp_nx ? AW'(need - 1'b1)
                            : AW'(BEATS-1);
        hdr_size <= comp_nx ? sz
                            : SIZE_W'(DW*BEATS);
        hdr_comp <= comp_nx;
      end
      if (out_hs) ocnt <= ocnt + AW'(1);
    end
  end

  assign blk_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign enc_valid = (state == ISSUE);
  assign enc_data  = enc_valid ? raw_rd : '0;
  assign enc_sop   = enc_valid && (icnt == '0);
  assign enc_eop   = enc_valid
                  && (icnt == AW'(BEATS-1));
  assign out_valid = (state == EMIT);
  assign out_last  = out_valid && (ocnt == olast);

  // Payload select; a zero-size compressed block carries a zero beat.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      if (!comp_q)     out_data = raw_rd;
      else if (!zero_q) out_data = stg_rd;
    end
  end

endmodule

// File: tb/tb_zrle_blk_ctrl.sv
// Randomized scoreboard bench for zrle_blk_ctrl.
// Expected beats come from a block-level reference model.
module tb_zrle_blk_ctrl;

  localparam int NB = 8;
  localparam int TO = 64;

  localparam int K_COMP   = 0;
  localparam int K_TRAIL  = 1;
  localparam int K_INCOMP = 2;
  localparam int K_TO     = 3;
  localparam int K_OVF    = 4;
  localparam int K_PERR   = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         enc_valid;
  logic         enc_ready = 1'b0;
  logic [63:0]  enc_data;
  logic         enc_sop;
  logic         enc_eop;
  logic         cb_d_valid = 1'b0;
  logic [63:0]  cb_data = '0;
  logic         cb_s_valid = 1'b0;
  logic [10:0]  cb_size = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_data;
  logic         out_last;
  logic [10:0]  hdr_size;
  logic         hdr_comp;
  logic         busy;
  logic         err_timeout;

  always #5 clk = ~clk;

  zrle_blk_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .blk_data    (blk_data),
    .enc_valid   (enc_valid),
    .enc_ready   (enc_ready),
    .enc_data    (enc_data),
    .enc_sop     (enc_sop),
    .enc_eop     (enc_eop),
    .cb_d_valid  (cb_d_valid),
    .cb_data     (cb_data),
    .cb_s_valid  (cb_s_valid),
    .cb_size     (cb_size),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .hdr_size    (hdr_size),
    .hdr_comp    (hdr_comp),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  typedef struct {
    logic [63:0] d;
    logic        last;
    logic [10:0] sz;
    logic        comp;
  } exp_t;

  typedef struct {
    logic        dv;
    logic [63:0] d;
    logic        sv;
    logic [10:0] sz;
  } cb_ev_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   pops = 0;
  int   to_pulses = 0;
  int   to_expected = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Downstream: accept about 70% of cycles.
  always @(posedge clk) begin
    #1 out_ready = ($urandom_range(0, 9) >= 3);
  end

  // Monitor: every output handshake pops one expected beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_timeout) to_pulses++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_extra", 64'(out_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", out_data, mon_e.d);
          chk("out_last", 64'(out_last), 64'(mon_e.last));
          chk("hdr_size", 64'(hdr_size), 64'(mon_e.sz));
          chk("hdr_comp", 64'(hdr_comp), 64'(mon_e.comp));
        end
        pops++;
      end
    end
  end

  task automatic run_block(input int kind,
                           input int szi,
                           input int rst_after);
    logic [511:0] blk;
    logic [63:0]  cbd [$];
    cb_ev_t       ev [$];
    cb_ev_t       e;
    exp_t         x;
    int           need;
    int           ncb;
    int           target;
    int           i;
    int           cyc;
    bit           comp;
    bit           done;

    for (int w = 0; w < 16; w++) blk[32*w +: 32] = $urandom;
    need = (szi == 0) ? 1 : (szi + 63) / 64;
    comp = (kind == K_COMP) || (kind == K_TRAIL);
    ncb  = comp ? need : (kind == K_INCOMP) ? 8 :
           (kind == K_OVF) ? 9 : 0;
    for (int b = 0; b < ncb; b++)
      cbd.push_back({$urandom, $urandom});

    // Code-buffer script, one entry per cycle after eop.
    for (int b = 0; b < ncb; b++) begin
      if (kind == K_TRAIL && b == ncb - 1) begin
        e = '{1'b0, 64'd0, 1'b1, 11'(szi)};
        ev.push_back(e);
        e = '{1'b0, 64'd0, 1'b0, 11'd0};
        ev.push_back(e);
      end
      e = '{1'b1, cbd[b], 1'b0, 11'd0};
      ev.push_back(e);
      if ($urandom_range(0, 1) == 1) begin
        e = '{1'b0, 64'd0, 1'b0, 11'd0};
        ev.push_back(e);
      end
    end
    if (kind == K_COMP) begin
      e = '{1'b0, 64'd0, 1'b1, 11'(szi)};
      ev.push_back(e);
    end
    if (kind == K_INCOMP) begin
      e = '{1'b0, 64'd0, 1'b1, 11'd513};
      ev.push_back(e);
    end

    // Reference: compressed payload, or the raw block.
    target = pops;
    if (comp) begin
      for (int b = 0; b < need; b++) begin
        x.d    = (szi == 0) ? 64'd0 : cbd[b];
        x.last = (b == need - 1);
        x.sz   = 11'(szi);
        x.comp = 1'b1;
        exp_q.push_back(x);
      end
      target += need;
    end else begin
      for (int b = 0; b < NB; b++) begin
        x.d    = blk[64*b +: 64];
        x.last = (b == NB - 1);
        x.sz   = 11'd512;
        x.comp = 1'b0;
        exp_q.push_back(x);
      end
      target += NB;
    end
    if (kind == K_TO) to_expected++;

    cyc = 0;
    while (!blk_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!blk_ready) begin
      chk("blk_ready_wait", 64'(blk_ready), 64'(1));
      exp_q.delete();
      return;
    end
    blk_valid = 1'b1;
    blk_data  = blk;
    @(negedge clk);
    blk_valid = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'(1));

    // Encoder side with 50% backpressure.
    i = 0;
    cyc = 0;
    while (i < NB && cyc < 200) begin
      enc_ready  = $urandom_range(0, 1);
      cb_s_valid = (kind == K_PERR) && (cyc == 0);
      cb_size    = 11'(szi);
      if (enc_valid && enc_ready) begin
        chk("enc_data", enc_data, blk[64*i +: 64]);
        chk("enc_sop", 64'(enc_sop), 64'(i == 0));
        chk("enc_eop", 64'(enc_eop), 64'(i == NB - 1));
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    enc_ready  = 1'b0;
    cb_s_valid = 1'b0;
    cb_size    = '0;
    if (i < NB) begin
      chk("enc_beats", 64'(i), 64'(NB));
      exp_q.delete();
      return;
    end

    // Code-buffer replay and output drain.
    done = 1'b0;
    for (int k = 1; k <= 400 && !done; k++) begin
      if (err_timeout && kind == K_TO)
        chk("timeout_cycle", 64'(k), 64'(TO + 1));
      if (rst_after >= 0 && pops >= target - NB + rst_after) begin
        #1 rst_n = 1'b0;
        cb_d_valid = 1'b0;
        cb_s_valid = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_blk_ready", 64'(blk_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (pops >= target) begin
        done = 1'b1;
      end else begin
        if (k - 1 < ev.size()) begin
          cb_d_valid = ev[k-1].dv;
          cb_data    = ev[k-1].d;
          cb_s_valid = ev[k-1].sv;
          cb_size    = ev[k-1].sz;
        end else begin
          cb_d_valid = 1'b0;
          cb_data    = '0;
          cb_s_valid = 1'b0;
          cb_size    = '0;
        end
        @(negedge clk);
      end
    end
    cb_d_valid = 1'b0;
    cb_s_valid = 1'b0;
    if (!done) begin
      chk("drain_pending", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_blk_ready", 64'(blk_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_enc_valid", 64'(enc_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err_timeout), 64'(0));
    chk("rst_hdr_size", 64'(hdr_size), 64'(0));
    chk("rst_hdr_comp", 64'(hdr_comp), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_block(K_COMP, 170, -1);
    run_block(K_TRAIL, 100, -1);
    run_block(K_INCOMP, 513, -1);
    run_block(K_TO, 0, -1);
    run_block(K_COMP, 0, -1);
    run_block(K_COMP, 512, -1);
    run_block(K_COMP, 64, -1);
    run_block(K_TRAIL, 65, -1);
    run_block(K_OVF, 0, -1);
    run_block(K_PERR, 64, -1);
    run_block(K_INCOMP, 513, 2);
    run_block(K_COMP, 170, -1);
    for (int n = 0; n < 30; n++)
      run_block($urandom_range(0, 5),
                $urandom_range(0, 512), -1);

    repeat (4) @(negedge clk);
    chk("timeout_pulses", 64'(to_pulses), 64'(to_expected));
    chk("idle_at_end", 64'(blk_ready), 64'(1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
